reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor of the processor's integer register file: 2 combinational read ports, 1 synchronous write port, and x0 hardwired to zero.
- Adds write-to-read bypass and a per-register pending scoreboard for hazard detection by decode.
- Adds a sequential clear engine that zeroes the whole file after a core restart without using the async reset.
- Sits between decode (read and issue) and writeback.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers including x0; power of 2, at least 4.
- ABITS, $clog2(NREGS), address width; derived, never overridden.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports; when 0 reads return stored contents only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ra0  in  ABITS  read address, port 0.
- rd0  out  XLEN  read data, port 0.
- ra1  in  ABITS  read address, port 1.
- rd1  out  XLEN  read data, port 1.
- we  in  1  write enable.
- wa  in  ABITS  write address.
- wd  in  XLEN  write data.
- iss_valid  in  1  an instruction with a destination register is issuing this cycle.
- iss_rd  in  ABITS  destination register of the issuing instruction.
- busy0  out  1  pending status of ra0.
- busy1  out  1  pending status of ra1.
- clr_req  in  1  start-clear request; single-cycle pulse.
- clr_busy  out  1  clear engine active.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers 0, all pending bits 0, FSM=IDLE, clear counter 0.
  - consequently rd0=rd1=0, busy0=busy1=0, clr_busy=0.
  - Release of reset is synchronised externally.
- Storage: NREGS-1 registers of XLEN bits (x1..x(NREGS-1)). x0 is not stored.
- Read, combinational, zero-cycle latency:
  - rdN = 0 if raN==0.
  - else wd if BYPASS && we && wa==raN && FSM==IDLE.
  - else stored value.
- Write: on rising edge, reg[wa] <= wd when we && wa!=0 && FSM==IDLE. Writes to x0 are discarded.
- Pending scoreboard (one bit per register 1..NREGS-1):
  - Set: iss_valid && iss_rd!=0 && FSM==IDLE sets pend[iss_rd].
  - Clear: we && wa!=0 && FSM==IDLE clears pend[wa].
  - Same register set and cleared in one cycle: set wins; the newer issue owns the register.
  - busyN = 1 if FSM==CLEAR.
  - else 0 if raN==0.
  - else 0 if BYPASS && we && wa==raN; the value is available this cycle.
  - else pend[raN].
  - busyN does not reflect a same-cycle issue; decode handles self-hazards.
- Clear FSM:
  - IDLE: clr_req moves to CLEAR on the next edge; counter <= 1 and all pend bits <= 0 on that edge.
  - CLEAR: each cycle reg[counter] <= 0, then counter++.
  - When counter==NREGS-1 that register is cleared and the FSM returns to IDLE.
  - CLEAR lasts exactly NREGS-1 cycles.
- clr_busy = (FSM==CLEAR), registered.
- In CLEAR, we, iss_valid and clr_req are ignored. Reads return current storage, which may be partially cleared. busy0/busy1 forced to 1 so decode stalls.
- Simultaneous clr_req with we/iss_valid in IDLE: that cycle's write and issue still take effect, then the clear wipes them (pend cleared, reg cleared when swept).
- Counter wrap: the counter is ABITS wide and never exceeds NREGS-1. The IDLE transition occurs before any wrap.
- Reset during CLEAR aborts immediately to the reset state.
- Out-of-range addresses are impossible, since NREGS is a power of 2.

Test Plan:
- Reset, then write x5=0xDEADBEEF; next cycle ra0=5 -> rd0=0xDEADBEEF. ra1=0 -> rd1=0.
- Write x0=0x1234, then ra0=0 -> rd0=0. In the write cycle, ra0=0 also gives 0 (no bypass to x0).
- BYPASS=1: we=1, wa=7, wd=0xA5A5A5A5, ra1=7 in the same cycle -> rd1=0xA5A5A5A5, busy1=0. With BYPASS=0 -> rd1 = old x7 and busy1 = pend[7].
- iss_valid, iss_rd=3 -> next cycle ra0=3 gives busy0=1. Then we, wa=3 in the same cycle as iss_valid, iss_rd=3 -> busy0 stays 1. Then we, wa=3 alone -> next cycle busy0=0.
- Load x1..x31 with nonzero values, pend[9]=1, pulse clr_req:
  - clr_busy=1 for exactly 31 cycles, busy0=1 throughout, a we to x4 mid-clear is ignored.
  - Afterwards all reads = 0 and busy0/busy1 = 0.
- Pull rst low at cycle 10 of a clear -> clr_busy=0, all registers 0 immediately. After release, a write to x2 works on the first edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// Integer register file: 2 comb read ports, 1 sync write port, x0 = 0, write bypass, pending scoreboard, sweep clear engine.
// Reads are zero latency. There is no backpressure; during a clear, writes and issues are dropped and busy0/busy1 stall decode.
module reg_file_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int ABITS = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ABITS-1:0] ra0,
   output logic [XLEN-1:0]  rd0,
   input  logic [ABITS-1:0] ra1,
   output logic [XLEN-1:0]  rd1,
   input  logic             we,
   input  logic [ABITS-1:0] wa,
   input  logic [XLEN-1:0]  wd,
   input  logic             iss_valid,
   input  logic [ABITS-1:0] iss_rd,
   output logic             busy0,
   output logic             busy1,
   input  logic             clr_req,
   output logic             clr_busy
);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   localparam logic [ABITS-1:0] LAST = ABITS'(NREGS - 1);

   state_t           state, state_nxt;
   logic [ABITS-1:0] cnt;
   logic [XLEN-1:0]  mem [1:NREGS-1];
   logic [NREGS-1:1] pend;

   logic             idle, wr_en, iss_en, clr_start, clr_last;
   logic [XLEN-1:0]  st0, st1;
   logic             pb0, pb1, byp0, byp1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (clr_start)
            cnt <= ABITS'(1);
         else if (state == CLEAR)
            cnt <= clr_last ? '0 : cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr_req)  state_nxt = CLEAR;
         CLEAR:   if (clr_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      idle      = (state == IDLE);
      clr_busy  = (state == CLEAR);
      wr_en     = we && (wa != '0) && idle;
      iss_en    = iss_valid && (iss_rd != '0) && idle;
      clr_start = idle && clr_req;
      clr_last  = (state == CLEAR) && (cnt == LAST);
   end

   // A same-cycle issue beats a writeback to the same register: the newer producer owns it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < NREGS; i++)
            mem[i] <= '0;
         pend <= '0;
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if ((state == CLEAR) && (cnt == ABITS'(i)))
               mem[i] <= '0;
            else if (wr_en && (wa == ABITS'(i)))
               mem[i] <= wd;

            if (clr_start)
               pend[i] <= 1'b0;
            else if (iss_en && (iss_rd == ABITS'(i)))
               pend[i] <= 1'b1;
            else if (wr_en && (wa == ABITS'(i)))
               pend[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      st0 = '0;
      st1 = '0;
      pb0 = 1'b0;
      pb1 = 1'b0;
      for (int i = 1; i < NREGS; i++) begin
         if (ra0 == ABITS'(i)) begin
            st0 = mem[i];
            pb0 = pend[i];
         end
         if (ra1 == ABITS'(i)) begin
            st1 = mem[i];
            pb1 = pend[i];
         end
      end
   end

   // busyN needs no idle qualifier on the bypass term: CLEAR already forces busy high.
   always_comb begin
      byp0  = (BYPASS != 0) && we && (wa == ra0);
      byp1  = (BYPASS != 0) && we && (wa == ra1);
      rd0   = (ra0 == '0) ? '0 : (byp0 && idle) ? wd : st0;
      rd1   = (ra1 == '0) ? '0 : (byp1 && idle) ? wd : st1;
      busy0 = clr_busy ? 1'b1 : (ra0 == '0) ? 1'b0 : byp0 ? 1'b0 : pb0;
      busy1 = clr_busy ? 1'b1 : (ra1 == '0) ? 1'b0 : byp1 ? 1'b0 : pb1;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: bypass and non-bypass instances share stimulus and are checked against a register-array model.
module tb_reg_file_sb;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int ABITS = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [ABITS-1:0] ra0, ra1, wa, iss_rd;
   logic             we, iss_valid, clr_req;
   logic [XLEN-1:0]  wd;
   logic [XLEN-1:0]  rd0_b, rd1_b, rd0_n, rd1_n;
   logic             busy0_b, busy1_b, busy0_n, busy1_n, clr_busy_b, clr_busy_n;

   always #5 clk = ~clk;

   reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .ra0(ra0), .rd0(rd0_b), .ra1(ra1), .rd1(rd1_b),
      .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .busy0(busy0_b), .busy1(busy1_b), .clr_req(clr_req), .clr_busy(clr_busy_b));

   reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .ra0(ra0), .rd0(rd0_n), .ra1(ra1), .rd1(rd1_n),
      .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .busy0(busy0_n), .busy1(busy1_n), .clr_req(clr_req), .clr_busy(clr_busy_n));

   int checks = 0;
   int errors = 0;

   // Architectural view: register contents, pending flags, and how much of a clear sweep remains.
   logic [XLEN-1:0] m_reg  [NREGS];
   bit              m_pend [NREGS];
   int              m_clr_left;

   typedef struct {
      logic             we;
      logic [ABITS-1:0] wa;
      logic [XLEN-1:0]  wd;
      logic             iv;
      logic [ABITS-1:0] ir;
      logic [ABITS-1:0] a0, a1;
      logic [XLEN-1:0]  e0, e1;
      logic             b0, b1;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mk(input logic w, input int a, input logic [XLEN-1:0] d,
                               input logic v, input int r, input int x0, input int x1,
                               input logic [XLEN-1:0] y0, input logic [XLEN-1:0] y1,
                               input logic z0, input logic z1);
      vec_t t;
      t.we = w;  t.wa = ABITS'(a);   t.wd = d;
      t.iv = v;  t.ir = ABITS'(r);
      t.a0 = ABITS'(x0); t.a1 = ABITS'(x1);
      t.e0 = y0; t.e1 = y1; t.b0 = z0; t.b1 = z1;
      return t;
   endfunction

   function automatic logic [XLEN-1:0] exp_rd(input logic [ABITS-1:0] ra, input bit byp);
      if (ra == 0) return '0;
      if (byp && we && wa == ra && m_clr_left == 0) return wd;
      return m_reg[ra];
   endfunction

   function automatic logic exp_busy(input logic [ABITS-1:0] ra, input bit byp);
      if (m_clr_left != 0) return 1'b1;
      if (ra == 0) return 1'b0;
      if (byp && we && wa == ra) return 1'b0;
      return m_pend[ra];
   endfunction

   task automatic cmp(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      cmp({tag, ".rd0_b"},   rd0_b,   exp_rd(ra0, 1));
      cmp({tag, ".rd1_b"},   rd1_b,   exp_rd(ra1, 1));
      cmp({tag, ".busy0_b"}, XLEN'(busy0_b), XLEN'(exp_busy(ra0, 1)));
      cmp({tag, ".busy1_b"}, XLEN'(busy1_b), XLEN'(exp_busy(ra1, 1)));
      cmp({tag, ".clr_b"},   XLEN'(clr_busy_b), XLEN'(m_clr_left != 0));
      cmp({tag, ".rd0_n"},   rd0_n,   exp_rd(ra0, 0));
      cmp({tag, ".rd1_n"},   rd1_n,   exp_rd(ra1, 0));
      cmp({tag, ".busy0_n"}, XLEN'(busy0_n), XLEN'(exp_busy(ra0, 0)));
      cmp({tag, ".busy1_n"}, XLEN'(busy1_n), XLEN'(exp_busy(ra1, 0)));
      cmp({tag, ".clr_n"},   XLEN'(clr_busy_n), XLEN'(m_clr_left != 0));
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_reg[i]  = '0;
         m_pend[i] = 1'b0;
      end
      m_clr_left = 0;
   endtask

   // Called just after a rising edge, while the inputs of the finished cycle are still applied.
   task automatic model_edge();
      if (m_clr_left != 0) begin
         m_reg[NREGS - m_clr_left] = '0;
         m_clr_left--;
      end else begin
         if (we && wa != 0) begin
            m_reg[wa]  = wd;
            m_pend[wa] = 1'b0;
         end
         if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
         if (clr_req) begin
            for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
            m_clr_left = NREGS - 1;
         end
      end
   endtask

   task automatic cycle(input string tag);
      #1;
      check_model(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_in();
      we = 0; wa = '0; wd = '0; iss_valid = 0; iss_rd = '0; clr_req = 0;
   endtask

   initial begin
      int n;
      idle_in();
      ra0 = '0; ra1 = '0;
      model_reset();
      #1 rst = 1'b0;
      #10;
      ra0 = 5'd5; ra1 = 5'd31;
      #1;
      cmp("reset.rd0", rd0_b, '0);
      cmp("reset.busy1", XLEN'(busy1_b), '0);
      cmp("reset.clr_busy", XLEN'(clr_busy_b), '0);
      @(posedge clk); #1 rst = 1'b1;

      tbl[0]  = mk(0, 0, 0,            0, 0, 5, 0, 0,            0,            0, 0);
      tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,            0,            0, 0);
      tbl[2]  = mk(0, 0, 0,            0, 0, 5, 0, 32'hDEADBEEF, 0,            0, 0);
      tbl[3]  = mk(1, 0, 32'h1234,     0, 0, 0, 5, 0,            32'hDEADBEEF, 0, 0);
      tbl[4]  = mk(0, 0, 0,            0, 0, 0, 0, 0,            0,            0, 0);
      tbl[5]  = mk(1, 7, 32'hA5A5A5A5, 0, 0, 5, 7, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0);
      tbl[6]  = mk(0, 0, 0,            1, 3, 3, 7, 0,            32'hA5A5A5A5, 0, 0);
      tbl[7]  = mk(0, 0, 0,            0, 0, 3, 7, 0,            32'hA5A5A5A5, 1, 0);
      tbl[8]  = mk(1, 3, 32'h11,       1, 3, 3, 0, 32'h11,       0,            0, 0);
      tbl[9]  = mk(0, 0, 0,            0, 0, 3, 0, 32'h11,       0,            1, 0);
      tbl[10] = mk(1, 3, 32'h22,       0, 0, 0, 3, 0,            32'h22,       0, 0);
      tbl[11] = mk(0, 0, 0,            0, 0, 3, 3, 32'h22,       32'h22,       0, 0);
      tbl[12] = mk(0, 0, 0,            1, 7, 0, 7, 0,            32'hA5A5A5A5, 0, 0);
      tbl[13] = mk(1, 7, 32'h5A5A,     0, 0, 3, 7, 32'h22,       32'h5A5A,     0, 0);

      for (int k = 0; k < 14; k++) begin
         we = tbl[k].we; wa = tbl[k].wa; wd = tbl[k].wd;
         iss_valid = tbl[k].iv; iss_rd = tbl[k].ir; clr_req = 0;
         ra0 = tbl[k].a0; ra1 = tbl[k].a1;
         #1;
         cmp($sformatf("vec%0d.rd0", k), rd0_b, tbl[k].e0);
         cmp($sformatf("vec%0d.rd1", k), rd1_b, tbl[k].e1);
         cmp($sformatf("vec%0d.busy0", k), XLEN'(busy0_b), XLEN'(tbl[k].b0));
         cmp($sformatf("vec%0d.busy1", k), XLEN'(busy1_b), XLEN'(tbl[k].b1));
         cycle("vec");
      end

      // Fill every register, leave x9 pending, then sweep-clear.
      for (int i = 1; i < NREGS; i++) begin
         idle_in();
         we = 1; wa = ABITS'(i); wd = (XLEN'(i) * 32'h01010101) | 32'h1;
         if (i == NREGS - 1) begin iss_valid = 1; iss_rd = 5'd9; end
         cycle("load");
      end
      idle_in();
      ra0 = 5'd9;
      #1 cmp("pend9", XLEN'(busy0_b), 1);
      clr_req = 1;
      cycle("clr_req");
      clr_req = 0;
      n = 0;
      while (clr_busy_b === 1'b1 && n < 100) begin
         we = (n == 5); wa = 5'd4; wd = '1;
         ra0 = ABITS'(n); ra1 = 5'd4;
         #1 cmp("clr.busy0", XLEN'(busy0_b), 1);
         cycle("clr");
         n++;
      end
      cmp("clr_len", XLEN'(n), XLEN'(NREGS - 1));
      idle_in();
      for (int i = 0; i < NREGS; i++) begin
         ra0 = ABITS'(i); ra1 = ABITS'(NREGS - 1 - i);
         #1;
         cmp($sformatf("post_clr.rd0[%0d]", i), rd0_b, '0);
         cmp("post_clr.busy1", XLEN'(busy1_b), '0);
      end

      // Abort a clear with reset partway through.
      x_fill();
      clr_req = 1;
      cycle("clr2");
      clr_req = 0;
      for (int i = 0; i < 10; i++) cycle("clr2");
      rst = 1'b0;
      model_reset();
      #1 cmp("rst_abort.clr_busy", XLEN'(clr_busy_b), '0);
      for (int i = 1; i < NREGS; i++) begin
         ra0 = ABITS'(i);
         #1 cmp($sformatf("rst_abort.rd0[%0d]", i), rd0_b, '0);
      end
      @(posedge clk); #1 rst = 1'b1;
      we = 1; wa = 5'd2; wd = 32'hCAFEF00D; ra0 = 5'd0;
      cycle("rst_wr");
      idle_in();
      ra0 = 5'd2;
      #1 cmp("rst_wr.rd0", rd0_b, 32'hCAFEF00D);

      for (int k = 0; k < 3000; k++) begin
         we = 1'($urandom); wa = ABITS'($urandom); wd = $urandom;
         iss_valid = 1'($urandom); iss_rd = ABITS'($urandom);
         clr_req = ($urandom_range(63) == 0);
         ra0 = (k % 3 == 0) ? wa : ABITS'($urandom);
         ra1 = (k % 5 == 0) ? iss_rd : ABITS'($urandom);
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   task automatic x_fill();
      for (int i = 1; i < NREGS; i++) begin
         idle_in();
         we = 1; wa = ABITS'(i); wd = ~XLEN'(i);
         cycle("fill2");
      end
      idle_in();
   endtask

endmodule
